// File: rtl/hazard3_regfile_1wnr_clr.sv
// hazard3_regfile_1wnr_clr: 1-write N-read register file with a post-reset clear sequencer.
// Optional macro HAZARD3_REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module hazard3_regfile_1wnr_clr #(
    parameter int N_REGS    = 32,
    parameter int W_DATA    = 32,
    parameter int W_ADDR    = 5,
    parameter int N_RPORTS  = 2,
    parameter int ZERO_REG0 = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_RPORTS*W_ADDR-1:0]   raddr,
    input  logic [N_RPORTS-1:0]          ren,
    output logic [N_RPORTS*W_DATA-1:0]   rdata,
    input  logic [W_ADDR-1:0]            waddr,
    input  logic [W_DATA-1:0]            wdata,
    input  logic                         wen,
    output logic                         busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [W_ADDR:0]   NREGS_W = (W_ADDR+1)'(N_REGS);
    localparam logic [W_ADDR-1:0] LAST    = W_ADDR'(N_REGS - 1);

    state_t              state;
    logic [W_ADDR-1:0]   clr_addr;
    logic [W_DATA-1:0]   mem [N_REGS];
    logic                w_valid;
    logic [W_ADDR-1:0]   ra     [N_RPORTS];
    logic [W_DATA-1:0]   rd_val [N_RPORTS];

    assign w_valid = rst_n && state == RUN && wen && ({1'b0, waddr} < NREGS_W)
                     && !(ZERO_REG0 != 0 && waddr == '0);

    // Clear sequencer: zero one register per cycle, stop at the last one without wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else if (state == CLEAR) begin
            if (clr_addr == LAST) begin
                state <= RUN;
                busy  <= 1'b0;
            end else begin
                clr_addr <= clr_addr + W_ADDR'(1);
            end
        end
    end

    // Storage has no reset so it maps to RAM; the sequencer owns the write port while clearing
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_addr] <= '0;
        else if (w_valid)
            mem[waddr] <= wdata;
    end

    // Per-port read value: zero for reg0/out-of-range, optionally forwarding the colliding write
    always_comb begin
        for (int k = 0; k < N_RPORTS; k++) begin
            ra[k]     = raddr[k*W_ADDR +: W_ADDR];
            rd_val[k] = (({1'b0, ra[k]} >= NREGS_W) || (ZERO_REG0 != 0 && ra[k] == '0))
                        ? '0 : mem[ra[k]];
`ifdef HAZARD3_REGFILE_BYPASS_EN
            if (w_valid && ren[k] && ra[k] == waddr)
                rd_val[k] = wdata;
`endif
        end
    end

    // Registered read data, updated only in RUN for enabled ports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (state == RUN) begin
            for (int k = 0; k < N_RPORTS; k++)
                if (ren[k])
                    rdata[k*W_DATA +: W_DATA] <= rd_val[k];
        end
    end

endmodule

// File: doc/hazard3_regfile_1wnr_clr.md
HAZARD3_REGFILE_1WNR_CLR -- requirements
Module: hazard3_regfile_1wnr_clr

Interface
REQ-001 SHALL have parameter N_REGS, default 32, number of registers (2..64).
REQ-002 SHALL have parameter W_DATA, default 32, register width in bits.
REQ-003 SHALL have parameter W_ADDR, default 5, address width; 2**W_ADDR >= N_REGS.
REQ-004 SHALL have parameter N_RPORTS, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter ZERO_REG0, default 1; when 1, register 0 is hardwired to zero.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port raddr  input  N_RPORTS*W_ADDR  packed read addresses; port k at bits [k*W_ADDR +: W_ADDR].
REQ-009 SHALL have port ren  input  N_RPORTS  per-port read enable.
REQ-010 SHALL have port rdata  output  N_RPORTS*W_DATA  packed registered read data; port k at bits [k*W_DATA +: W_DATA].
REQ-011 SHALL have port waddr  input  W_ADDR  write address.
REQ-012 SHALL have port wdata  input  W_DATA  write data.
REQ-013 SHALL have port wen  input  1  write enable.
REQ-014 SHALL have port busy  output  1  high while the clear sequencer runs; writes and reads are not serviced.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR, SHALL write zero to one register per cycle via counter clr_addr, from 0 up to N_REGS-1.
REQ-017 SHALL move CLEAR->RUN on the cycle after writing register N_REGS-1; the total clear takes exactly N_REGS cycles after reset deasserts; the counter SHALL NOT wrap to 2**W_ADDR when N_REGS is not a power of two.
REQ-018 SHALL assert busy in every CLEAR cycle; busy SHALL be 0 in RUN.
REQ-019 In CLEAR, SHALL ignore wen and ignore ren; rdata SHALL stay zero.
REQ-020 In RUN, SHALL write wdata to mem[waddr] when wen=1, waddr < N_REGS and not (ZERO_REG0=1 and waddr=0); otherwise SHALL leave memory unchanged.
REQ-021 In RUN, for each port k with ren[k]=1, SHALL load rdata port k with the contents of raddr port k one cycle later (latency 1).
REQ-022 With ren[k]=0, rdata port k SHALL hold its previous value.
REQ-023 A read of address 0 with ZERO_REG0=1, or of any address >= N_REGS, SHALL return zero.
REQ-024 Any number of read ports SHALL be able to read the same address in the same cycle, with identical results.
REQ-025 Storage SHALL have no reset term, so that it can be inferred as RAM; zeroing SHALL be done only by the clear sequencer.

Reset
REQ-026 While rst_n=0 at a clk edge: FSM->CLEAR, clr_addr->0, busy->1, all rdata->0.
REQ-027 If reset asserts during CLEAR, the sequence SHALL restart at address 0.
REQ-028 If reset asserts during RUN, the full CLEAR sequence SHALL run again.

Configuration
REQ-029 Macro HAZARD3_REGFILE_BYPASS_EN, when defined, SHALL forward wdata to port k if in the same RUN cycle ren[k]=1, wen=1, raddr k = waddr, and the write is valid under REQ-020; rdata k then equals wdata the next cycle.
REQ-030 Without HAZARD3_REGFILE_BYPASS_EN, the same collision SHALL return the old contents (read-before-write); the new value is visible from the following read.

Verification
REQ-031 Reset with N_REGS=32, release -> busy=1 for exactly 32 cycles, then 0; reads of all 32 registers return 0.
REQ-032 RUN: write 0xDEADBEEF to x5, next cycle ren=all raddr=5 -> all ports return 0xDEADBEEF one cycle later.
REQ-033 Write 0x12345678 to x0 (ZERO_REG0=1) -> read x0 returns 0; with ZERO_REG0=0 it returns 0x12345678.
REQ-034 x7=0x1, same cycle wen x7=0x2 and ren x7 -> 0x2 with BYPASS_EN, 0x1 without.
REQ-035 Hold: read x3=0xA5A5A5A5, then ren=0 while x3 is rewritten to 0 -> rdata stays 0xA5A5A5A5.
REQ-036 N_REGS=20, W_ADDR=5: assert reset at clear cycle 10 -> restart, busy for 20 further cycles; write and read at addr 25 -> returns 0; wen asserted during busy -> no effect.
